// File: rtl/text_console_pkg.sv
// Shared constants, control codes and FSM state type for the text console writer.
package text_console_pkg;

    localparam int COLS   = 64;
    localparam int ROWS   = 32;
    localparam int ADDR_W = 11;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 5;

    localparam logic [7:0] BLANK = 8'h20;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] FF    = 8'h0C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        ROWCLR = 2'd2,
        SCRCLR = 2'd3
    } state_t;

    // Codes that land in video RAM as glyphs.
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream in, video RAM write port out.
// Handshake: a character transfers on a rising clk edge where char_valid and
// char_ready are both high; char_valid/char_data must be held stable until
// then. clear_req is a single-cycle pulse with no handshake. write_ce marks a
// cycle in which write_ad/write_data must be written to video RAM.
interface text_console_writer_if
    import text_console_pkg::*;
;
    logic              char_valid;
    logic [7:0]        char_data;
    logic              char_ready;
    logic              clear_req;
    logic              write_ce;
    logic [ADDR_W-1:0] write_ad;
    logic [7:0]        write_data;

    modport master (
        output char_valid, char_data, clear_req,
        input  char_ready, write_ce, write_ad, write_data
    );

    modport slave (
        input  char_valid, char_data, clear_req,
        output char_ready, write_ce, write_ad, write_data
    );
endinterface

// File: rtl/text_console_writer.sv
// Text console writer: turns a character stream into video RAM writes,
// tracking a cursor and blanking rows or the whole screen as needed.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS  = text_console_pkg::COLS,
    parameter int         ROWS  = text_console_pkg::ROWS,
    parameter logic [7:0] BLANK = text_console_pkg::BLANK
) (
    input  logic                    clk,
    input  logic                    reset,
    text_console_writer_if.slave    bus,
    output logic                    busy,
    output logic [COL_W-1:0]        cursor_col,
    output logic [ROW_W-1:0]        cursor_row,
    output state_t                  dbg_state
);

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    state_t             state, state_nx;
    logic [COL_W-1:0]   col, col_nx;
    logic [ROW_W-1:0]   row, row_nx, row_inc;
    logic               clr_pend, clr_pend_nx;
    logic               ready_en;
    logic               adv, adv_nx;
    logic [ADDR_W-1:0]  fill, fill_nx;
    logic               ce, ce_nx;
    logic [ADDR_W-1:0]  ad, ad_nx;
    logic [7:0]         wd, wd_nx;
    logic               accept;

    // ready_en keeps char_ready low until the first edge after reset.
    assign bus.char_ready = ready_en && (state == IDLE) && !clr_pend;
    assign accept         = bus.char_valid && bus.char_ready;
    assign row_inc        = (row == LAST_ROW) ? '0 : row + 1'b1;

    assign bus.write_ce   = ce;
    assign bus.write_ad   = ad;
    assign bus.write_data = wd;
    assign busy           = (state != IDLE);
    assign cursor_col     = col;
    assign cursor_row     = row;
    assign dbg_state      = state;

    // State, cursor, fill counter and registered RAM write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            clr_pend <= 1'b0;
            ready_en <= 1'b0;
            adv      <= 1'b0;
            fill     <= '0;
            ce       <= 1'b0;
            ad       <= '0;
            wd       <= '0;
        end else begin
            state    <= state_nx;
            col      <= col_nx;
            row      <= row_nx;
            clr_pend <= clr_pend_nx;
            ready_en <= 1'b1;
            adv      <= adv_nx;
            fill     <= fill_nx;
            ce       <= ce_nx;
            ad       <= ad_nx;
            wd       <= wd_nx;
        end
    end

    // Next-state and next write-port values; the write port is loaded on the
    // edge that enters a writing state so write_ce lines up with that state.
    always_comb begin
        state_nx    = state;
        col_nx      = col;
        row_nx      = row;
        clr_pend_nx = clr_pend | bus.clear_req;
        adv_nx      = adv;
        fill_nx     = fill;
        ce_nx       = 1'b0;
        ad_nx       = ad;
        wd_nx       = wd;

        case (state)
            IDLE: begin
                if (clr_pend) begin
                    // Pending clear wins over any offered character.
                    state_nx    = SCRCLR;
                    clr_pend_nx = bus.clear_req;
                    fill_nx     = '0;
                    ce_nx       = 1'b1;
                    ad_nx       = '0;
                    wd_nx       = BLANK;
                end else if (accept) begin
                    if (is_printable(bus.char_data)) begin
                        state_nx = WRITE;
                        adv_nx   = 1'b1;
                        ce_nx    = 1'b1;
                        ad_nx    = {row, col};
                        wd_nx    = bus.char_data;
                    end else begin
                        case (bus.char_data)
                            CR: col_nx = '0;
                            LF: begin
                                row_nx   = row_inc;
                                state_nx = ROWCLR;
                                fill_nx  = '0;
                                ce_nx    = 1'b1;
                                ad_nx    = {row_inc, {COL_W{1'b0}}};
                                wd_nx    = BLANK;
                            end
                            BS: begin
                                if (col != '0) begin
                                    col_nx   = col - 1'b1;
                                    state_nx = WRITE;
                                    adv_nx   = 1'b0;
                                    ce_nx    = 1'b1;
                                    ad_nx    = {row, col - 1'b1};
                                    wd_nx    = BLANK;
                                end
                            end
                            FF:      clr_pend_nx = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end

            WRITE: begin
                state_nx = IDLE;
                if (adv) begin
                    if (col == LAST_COL) begin
                        // End of line: wrap to the next row and blank it.
                        col_nx   = '0;
                        row_nx   = row_inc;
                        state_nx = ROWCLR;
                        fill_nx  = '0;
                        ce_nx    = 1'b1;
                        ad_nx    = {row_inc, {COL_W{1'b0}}};
                        wd_nx    = BLANK;
                    end else begin
                        col_nx = col + 1'b1;
                    end
                end
            end

            ROWCLR: begin
                if (fill[COL_W-1:0] == LAST_COL) begin
                    state_nx = IDLE;
                end else begin
                    fill_nx = fill + 1'b1;
                    ce_nx   = 1'b1;
                    ad_nx   = {row, fill[COL_W-1:0] + 1'b1};
                end
            end

            SCRCLR: begin
                if (fill == LAST_ADDR) begin
                    state_nx = IDLE;
                    col_nx   = '0;
                    row_nx   = '0;
                end else begin
                    fill_nx = fill + 1'b1;
                    ce_nx   = 1'b1;
                    ad_nx   = fill + 1'b1;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a write scoreboard.
module tb_text_console_writer;
    import text_console_pkg::*;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    state_t      dbg_state;

    text_console_writer_if bus();

    text_console_writer dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    logic [18:0] exp_q[$];
    logic [5:0]  mcol;
    logic [4:0]  mrow;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_w(input logic [10:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic push_row(input logic [4:0] r);
        for (int i = 0; i < 64; i++) push_w({r, 6'(i)}, 8'h20);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2048; i++) push_w(11'(i), 8'h20);
        mcol = '0;
        mrow = '0;
    endtask

    // Reference behaviour of one accepted character.
    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_w({mrow, mcol}, c);
            if (mcol == 6'd63) begin
                mcol = '0;
                mrow = mrow + 1'b1;
                push_row(mrow);
            end else begin
                mcol = mcol + 1'b1;
            end
        end else if (c == 8'h0D) begin
            mcol = '0;
        end else if (c == 8'h0A) begin
            mrow = mrow + 1'b1;
            push_row(mrow);
        end else if (c == 8'h08) begin
            if (mcol != '0) begin
                mcol = mcol - 1'b1;
                push_w({mrow, mcol}, 8'h20);
            end
        end else if (c == 8'h0C) begin
            model_clear();
        end
    endtask

    // Scoreboard: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.write_ce) begin
            logic [18:0] e;
            wr_count++;
            check("busy_during_write", 32'(busy), 1);
            check("sb_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.write_ad), 32'(e[18:8]));
                check("wr_data", 32'(bus.write_data), 32'(e[7:0]));
            end
        end
    end

    task automatic send_char(input logic [7:0] c);
        int n;
        model_char(c);
        n = 0;
        @(negedge clk);
        while (!bus.char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 32'(bus.char_ready), 1);
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        @(posedge clk);
        #1;
        bus.char_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        model_clear();
        @(negedge clk);
        bus.clear_req = 1'b1;
        @(posedge clk);
        #1;
        bus.clear_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy || exp_q.size() != 0), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_write_ce", 32'(bus.write_ce), 0);
        check("rst_write_ad", 32'(bus.write_ad), 0);
        check("rst_write_data", 32'(bus.write_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_char_ready", 32'(bus.char_ready), 0);
        check("rst_cursor_col", 32'(cursor_col), 0);
        check("rst_cursor_row", 32'(cursor_row), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        int w0;
        int n;
        reset          = 1'b0;
        bus.char_valid = 1'b0;
        bus.char_data  = '0;
        bus.clear_req  = 1'b0;
        mcol           = '0;
        mrow           = '0;

        // Reset values and char_ready rising on the first edge after release.
        #22;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_before_edge", 32'(bus.char_ready), 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(bus.char_ready), 1);

        // 'A' at home: write one cycle after acceptance, cursor advances.
        send_char(8'h41);
        check("a_write_ce", 32'(bus.write_ce), 1);
        check("a_write_ad", 32'(bus.write_ad), 0);
        check("a_write_data", 32'(bus.write_data), 32'h41);
        @(posedge clk);
        #1;
        check("a_write_ce_drop", 32'(bus.write_ce), 0);
        wait_idle();
        check("a_cursor_col", 32'(cursor_col), 1);

        // Walk the cursor to (63,31) then print at the last cell.
        send_char(8'h0D);
        for (int i = 0; i < 31; i++) send_char(8'h0A);
        for (int i = 0; i < 63; i++) send_char(8'($urandom_range(32'h20, 32'h7E)));
        wait_idle();
        check("corner_col", 32'(cursor_col), 63);
        check("corner_row", 32'(cursor_row), 31);
        send_char(8'h5A);
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            check("z_char_ready_low", 32'(bus.char_ready), 0);
        end
        wait_idle();
        check("z_cursor_col", 32'(cursor_col), 0);
        check("z_cursor_row", 32'(cursor_row), 0);

        // clear_req during a row clear: row finishes, then full-screen clear.
        w0 = wr_count;
        send_char(8'h0A);
        repeat (10) @(negedge clk);
        pulse_clear();
        wait_idle();
        check("clr_write_count", 32'(wr_count - w0), 64 + 2048);
        check("clr_cursor_col", 32'(cursor_col), 0);
        check("clr_cursor_row", 32'(cursor_row), 0);

        // Backspace at column 0 and after "AB".
        w0 = wr_count;
        send_char(8'h08);
        wait_idle();
        check("bs0_no_write", 32'(wr_count - w0), 0);
        check("bs0_cursor_col", 32'(cursor_col), 0);
        send_char(8'h41);
        send_char(8'h42);
        send_char(8'h08);
        wait_idle();
        check("bs_cursor_col", 32'(cursor_col), 1);
        check("bs_hold_ad", 32'(bus.write_ad), 1);
        check("bs_hold_data", 32'(bus.write_data), 32'h20);

        // Unknown code, CR and form feed.
        w0 = wr_count;
        send_char(8'h01);
        wait_idle();
        check("other_no_write", 32'(wr_count - w0), 0);
        check("other_cursor_col", 32'(cursor_col), 1);
        send_char(8'h0D);
        wait_idle();
        check("cr_cursor_col", 32'(cursor_col), 0);
        send_char(8'h51);
        send_char(8'h0A);
        send_char(8'h0C);
        wait_idle();
        check("ff_cursor_col", 32'(cursor_col), 0);
        check("ff_cursor_row", 32'(cursor_row), 0);

        // Reset in the middle of a screen clear.
        pulse_clear();
        n = 0;
        while (!bus.write_ce && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scrclr_start", 32'(bus.write_ce), 1);
        repeat (1000) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_ce_drop", 32'(bus.write_ce), 0);
        exp_q.delete();
        mcol = '0;
        mrow = '0;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset = 1'b1;
        send_char(8'h41);
        check("post_rst_ad", 32'(bus.write_ad), 0);
        check("post_rst_data", 32'(bus.write_data), 32'h41);
        wait_idle();
        check("post_rst_col", 32'(cursor_col), 1);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 SHALL have parameter COLS, default 64, meaning characters per row; fixed power of two.
REQ-002 SHALL have parameter ROWS, default 32, meaning rows; COLS*ROWS = 2048 matches the 11-bit video RAM address space.
REQ-003 SHALL have parameter BLANK, default 8'h20, meaning the fill character for clears.
REQ-004 clk  input  1  single clock; all logic on posedge; also drives the video RAM write_clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 char_valid  input  1  upstream character offered.
REQ-007 char_data  input  8  character code.
REQ-008 char_ready  output  1  writer can accept a character this cycle.
REQ-009 clear_req  input  1  single-cycle request to clear the screen.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 write_ce  output  1  video RAM write enable.
REQ-012 write_ad  output  11  video RAM address, {row[4:0], col[5:0]}.
REQ-013 write_data  output  8  video RAM write data.
REQ-014 cursor_col  output  6  current column; cursor_row  output  5  current row.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, ROWCLR and SCRCLR.
REQ-016 char_ready SHALL equal (state==IDLE && !clr_pend); a character is accepted on a clk edge with char_valid && char_ready.
REQ-017 Printable codes 8'h20-8'h7E SHALL be handled as follows.
  - Transition IDLE->WRITE.
  - On the next cycle: write_ce=1, write_ad={row,col}, write_data=char; then return to IDLE.
  - Latency from acceptance edge to write_ce high SHALL be one cycle.
  - Cursor SHALL advance col+1 on the write cycle.
REQ-018 At col==COLS-1, a printable SHALL write, then set col=0 and row=row+1 (mod ROWS), then enter ROWCLR.
REQ-019 8'h0D (CR) SHALL set col=0 with no write and stay in IDLE.
REQ-020 8'h0A (LF) SHALL set row=row+1 (mod ROWS) with col unchanged, then enter ROWCLR.
REQ-021 8'h08 (BS) with col>0 SHALL set col=col-1, then write BLANK at the new position via WRITE; BS at col==0 SHALL do nothing.
REQ-022 8'h0C (FF) SHALL behave as clear_req.
REQ-023 All other codes SHALL be consumed with no write and no cursor change.
REQ-024 ROWCLR SHALL write BLANK to the 64 addresses {row,0..63}, one per cycle with write_ce held high, then return to IDLE; the cursor is unchanged.
REQ-025 SCRCLR SHALL write BLANK to addresses 0..2047, one per cycle, then set cursor to (0,0) and return to IDLE.
REQ-026 clear_req SHALL set a sticky clr_pend flag in any state.
  - clr_pend SHALL be serviced on the first IDLE cycle, and takes priority over char_valid in that same cycle.
  - clr_pend SHALL be cleared on entry to SCRCLR.
REQ-027 Row wrap from ROWS-1 SHALL go to 0; there is no scrolling, and the new row is blanked instead.
REQ-028 write_ce SHALL be 0 in IDLE; write_ad and write_data hold their last values when write_ce=0.

Reset
REQ-029 Asserting reset low SHALL immediately set the following:
  - state=IDLE, cursor (0,0), clr_pend=0;
  - write_ce=0, write_ad=0, write_data=0;
  - busy=0, char_ready=0.
REQ-030 char_ready SHALL rise on the first clk edge after reset deasserts.
REQ-031 Reset mid-clear SHALL abort the clear with no further writes; video RAM contents are not restored.

Structure
REQ-032 Package text_console_pkg SHALL hold COLS, ROWS, ADDR_W=11, BLANK, the codes CR, LF, BS and FF, and the state enum.
REQ-033 The block SHALL be a single module with an inline 11-bit fill counter and no sub-modules.

Verification
REQ-034 Reset, then send 'A' (8'h41): write_ce high exactly one cycle after acceptance, write_ad=0, write_data=8'h41; cursor_col=1 afterwards.
REQ-035 Set cursor to col 63 row 31, send 'Z': write at address 2047, then 64 cycles writing 8'h20 to addresses 0..63; cursor (0,0) afterwards; char_ready low throughout.
REQ-036 Pulse clear_req while in ROWCLR: after the row clear completes, exactly 2048 BLANK writes occur, busy=1 for their duration, and the cursor ends at (0,0).
REQ-037 Send BS at col 0, then "AB" followed by BS: the first BS gives no write; the last BS writes 8'h20 at address 1 and leaves cursor_col=1.
REQ-038 Assert reset low midway (cycle 1000) through SCRCLR: write_ce drops to 0 asynchronously, all outputs return to their reset values, and a subsequent 'A' is written at address 0.
